dm_sb_arbiter: RTL and testbench
================================

DM_SB_ARBITER -- requirements
Module: dm_sb_arbiter

Interface
REQ-001 SHALL have parameter BusWidth, default 32, master/requester data and address width in bits (32 or 64).
REQ-002 SHALL have parameter NumReq, default 2, number of system-bus requesters (2..4); port 0 is the SBA engine.
REQ-003 SHALL have parameter TimeoutCycles, default 1024, maximum wait for a response after grant.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active low.
REQ-005 SHALL have port dmactive_i  in  1  debug module active; low acts as synchronous clear.
REQ-006 SHALL have requester ports, each indexed [NumReq-1:0]: req_i in 1; add_i in BusWidth; we_i in 1; wdata_i in BusWidth; be_i in BusWidth/8; gnt_o out 1; r_valid_o out 1; r_rdata_o out BusWidth; err_o out 1.
REQ-007 SHALL have master ports: master_req_o out 1; master_add_o out BusWidth; master_we_o out 1; master_wdata_o out BusWidth; master_be_o out BusWidth/8; master_gnt_i in 1; master_r_valid_i in 1; master_r_rdata_i in BusWidth.
REQ-008 SHALL have busy_o  out 1  high when state is not Idle.

Function
REQ-009 SHALL implement the states Idle, Hold and WaitResp, with at most one transaction outstanding.
REQ-010 Idle, any req_i set: SHALL pick a winner combinationally by round-robin, starting at index ptr_q, and drive that requester's add/we/wdata/be onto master_* with master_req_o=1 in the same cycle (zero-cycle latency).
REQ-011 Idle, winner and master_gnt_i=1: SHALL assert gnt_o[winner], register owner_q=winner, and go to WaitResp.
REQ-012 Idle, winner and no gnt: SHALL register owner_q=winner and go to Hold; the selection SHALL be frozen until granted.
REQ-013 Hold: SHALL drive owner_q's request; on master_gnt_i it SHALL assert gnt_o[owner_q] and go to WaitResp.
REQ-014 Requesters SHALL hold req_i and their payload until gnt_o; a req_i drop in Hold is a protocol violation, and the block SHALL still complete the handshake.
REQ-015 WaitResp: SHALL hold master_req_o=0; on master_r_valid_i it SHALL assert r_valid_o[owner_q] with r_rdata_o[owner_q]=master_r_rdata_i, set ptr_q=(owner_q+1) mod NumReq, and go to Idle.
REQ-016 A new request SHALL NOT be presented in the cycle the response returns; the earliest next master_req_o is the following cycle.
REQ-017 r_rdata_o of non-owners SHALL be 0; r_valid_o, gnt_o and err_o are one-hot or zero.
REQ-018 SHALL clear the timeout counter on entry to WaitResp and increment it each WaitResp cycle without r_valid; when it reaches TimeoutCycles-1, SHALL pulse err_o[owner_q] for 1 cycle, advance ptr_q and go to Idle.
REQ-019 master_r_valid_i outside WaitResp SHALL be dropped, and SHALL pulse spurious_o (out, 1) for 1 cycle.
REQ-020 If r_valid and the timeout terminal count occur in the same cycle, the response SHALL win and no err_o is raised.
REQ-021 The counter SHALL saturate and never wrap; its width SHALL be $clog2(TimeoutCycles).

Reset
REQ-022 On rst_ni low (asynchronous): state=Idle, ptr_q=0, owner_q=0, counter=0; every output SHALL be 0.
REQ-023 dmactive_i low SHALL apply the same clear synchronously, including mid-transaction; a later response for the aborted transaction SHALL be treated per REQ-019.

Structure
REQ-024 The arbiter state enum and an sb_req_t struct (add, we, wdata, be) SHALL reside in dm_pkg.
REQ-025 Round-robin selection SHALL be a combinational sub-module dm_sb_rr_pick (inputs: req vector, ptr; outputs: winner index, valid).

Verification
REQ-026 req_i=2'b01, gnt same cycle, r_valid 3 cycles later with rdata=0xDEADBEEF -> gnt_o[0] in cycle 0, r_valid_o[0] with 0xDEADBEEF, ptr_q=1.
REQ-027 req_i=2'b11 held for 4 transactions -> grant order 0,1,0,1; no overlapping master_req_o during WaitResp.
REQ-028 req_i=2'b01, gnt withheld 5 cycles, req_i[1] asserted in cycle 2 -> master_add_o stays add_i[0] throughout Hold, and gnt_o[0] is given first.
REQ-029 TimeoutCycles=8, grant and no r_valid -> err_o[owner] pulses in the 8th WaitResp cycle, then Idle; a later r_valid pulses spurious_o.
REQ-030 dmactive_i low in WaitResp -> Idle next cycle, ptr_q=0, outputs 0; rst_ni low mid-Hold -> immediate clear with no clock edge.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and helpers for the debug-module system-bus arbiter.
package dm_pkg;

    // Arbiter FSM states: at most one system-bus transaction is in flight.
    typedef enum logic [1:0] {
        SbIdle     = 2'd0,
        SbHold     = 2'd1,
        SbWaitResp = 2'd2
    } sb_state_e;

    // Widest supported bus; narrower instances zero-extend into the struct.
    localparam int unsigned SbMaxWidth = 64;
    localparam int unsigned SbMaxBe    = SbMaxWidth / 8;

    // One requester's transaction payload as it is forwarded to the master.
    typedef struct packed {
        logic [SbMaxWidth-1:0] add;
        logic                  we;
        logic [SbMaxWidth-1:0] wdata;
        logic [SbMaxBe-1:0]    be;
    } sb_req_t;

    // Width of an index/counter able to hold 0..n-1, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dm_sb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i.
module dm_sb_rr_pick
    import dm_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    parameter int unsigned PtrW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic [PtrW-1:0]   winner_o,
    output logic              valid_o
);

    // Scan from the farthest candidate back to ptr_i so the closest one wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % NumReq]) begin
                winner_o = PtrW'((int'(ptr_i) + i) % NumReq);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_sb_arbiter.sv
// System-bus arbiter for the debug module: round-robin over NumReq
// requesters, one outstanding transaction, response timeout with error.
module dm_sb_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 dmactive_i,
    input  logic [NumReq-1:0]                    req_i,
    input  logic [NumReq-1:0][BusWidth-1:0]      add_i,
    input  logic [NumReq-1:0]                    we_i,
    input  logic [NumReq-1:0][BusWidth-1:0]      wdata_i,
    input  logic [NumReq-1:0][BusWidth/8-1:0]    be_i,
    output logic [NumReq-1:0]                    gnt_o,
    output logic [NumReq-1:0]                    r_valid_o,
    output logic [NumReq-1:0][BusWidth-1:0]      r_rdata_o,
    output logic [NumReq-1:0]                    err_o,
    output logic                                 master_req_o,
    output logic [BusWidth-1:0]                  master_add_o,
    output logic                                 master_we_o,
    output logic [BusWidth-1:0]                  master_wdata_o,
    output logic [BusWidth/8-1:0]                master_be_o,
    input  logic                                 master_gnt_i,
    input  logic                                 master_r_valid_i,
    input  logic [BusWidth-1:0]                  master_r_rdata_i,
    output logic                                 spurious_o,
    output logic                                 busy_o
);

    localparam int unsigned PtrW = idx_width(NumReq);
    localparam int unsigned CntW = idx_width(TimeoutCycles);

    sb_state_e         state_q, state_d;
    logic [PtrW-1:0]   owner_q, owner_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [PtrW-1:0]   pick_idx;
    logic              pick_valid;
    logic [PtrW-1:0]   sel_idx;
    logic              mreq;
    logic [NumReq-1:0] gnt_vec, rvalid_vec, err_vec;
    logic              spurious;
    logic              out_en;
    sb_req_t           sel_req;
    logic              unused_sel_bits;

    dm_sb_rr_pick #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_rr_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    // Next-state, selection and per-requester handshake pulses.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        sel_idx    = owner_q;
        mreq       = 1'b0;
        gnt_vec    = '0;
        rvalid_vec = '0;
        err_vec    = '0;
        spurious   = 1'b0;
        unique case (state_q)
            SbIdle: begin
                spurious = master_r_valid_i;
                if (pick_valid) begin
                    sel_idx = pick_idx;
                    mreq    = 1'b1;
                    owner_d = pick_idx;
                    if (master_gnt_i) begin
                        gnt_vec[pick_idx] = 1'b1;
                        state_d           = SbWaitResp;
                        cnt_d             = '0;
                    end else begin
                        state_d = SbHold;
                    end
                end
            end
            SbHold: begin
                // Selection is frozen on owner_q even if its req_i drops.
                spurious = master_r_valid_i;
                mreq     = 1'b1;
                if (master_gnt_i) begin
                    gnt_vec[owner_q] = 1'b1;
                    state_d          = SbWaitResp;
                    cnt_d            = '0;
                end
            end
            SbWaitResp: begin
                // A response arriving on the terminal count still wins.
                if (master_r_valid_i) begin
                    rvalid_vec[owner_q] = 1'b1;
                    state_d             = SbIdle;
                    ptr_d = (owner_q == PtrW'(NumReq - 1)) ? '0 : owner_q + PtrW'(1);
                end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    err_vec[owner_q] = 1'b1;
                    state_d          = SbIdle;
                    ptr_d = (owner_q == PtrW'(NumReq - 1)) ? '0 : owner_q + PtrW'(1);
                end else if (cnt_q != {CntW{1'b1}}) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = SbIdle;
        endcase
        if (!dmactive_i) begin
            state_d = SbIdle;
            owner_d = '0;
            ptr_d   = '0;
            cnt_d   = '0;
        end
    end

    // Zero-extend the selected requester's payload into the shared struct.
    always_comb begin
        sel_req       = '0;
        sel_req.add   = SbMaxWidth'(add_i[sel_idx]);
        sel_req.we    = we_i[sel_idx];
        sel_req.wdata = SbMaxWidth'(wdata_i[sel_idx]);
        sel_req.be    = SbMaxBe'(be_i[sel_idx]);
    end

    assign unused_sel_bits = ^{sel_req.add, sel_req.wdata, sel_req.be};

    // State registers, cleared asynchronously by rst_ni.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SbIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while in reset or while the DM is inactive.
    assign out_en         = rst_ni & dmactive_i;
    assign master_req_o   = out_en & mreq;
    assign master_add_o   = master_req_o ? sel_req.add[BusWidth-1:0]     : '0;
    assign master_we_o    = master_req_o & sel_req.we;
    assign master_wdata_o = master_req_o ? sel_req.wdata[BusWidth-1:0]   : '0;
    assign master_be_o    = master_req_o ? sel_req.be[BusWidth/8-1:0]    : '0;
    assign gnt_o          = out_en ? gnt_vec    : '0;
    assign r_valid_o      = out_en ? rvalid_vec : '0;
    assign err_o          = out_en ? err_vec    : '0;
    assign spurious_o     = out_en & spurious;
    assign busy_o         = out_en & (state_q != SbIdle);

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_rdata
        assign r_rdata_o[gi] = r_valid_o[gi] ? master_r_rdata_i : '0;
    end

endmodule

// File: tb/tb_dm_sb_arbiter.sv
// Directed and randomized check of dm_sb_arbiter against a transaction model.
module tb_dm_sb_arbiter;

    localparam int BW = 32;
    localparam int NR = 2;
    localparam int TC = 8;

    logic clk = 1'b0;
    logic rst_ni, dmactive;
    logic [NR-1:0]            req, we;
    logic [NR-1:0][BW-1:0]    add, wdata;
    logic [NR-1:0][BW/8-1:0]  be;
    logic                     mgnt, mrv;
    logic [BW-1:0]            mrdata;

    logic [NR-1:0]            gnt_o, r_valid_o, err_o;
    logic [NR-1:0][BW-1:0]    r_rdata_o;
    logic                     master_req_o, master_we_o, spurious_o, busy_o;
    logic [BW-1:0]            master_add_o, master_wdata_o;
    logic [BW/8-1:0]          master_be_o;

    always #5 clk = ~clk;

    dm_sb_arbiter #(
        .BusWidth      (BW),
        .NumReq        (NR),
        .TimeoutCycles (TC)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .dmactive_i       (dmactive),
        .req_i            (req),
        .add_i            (add),
        .we_i             (we),
        .wdata_i          (wdata),
        .be_i             (be),
        .gnt_o            (gnt_o),
        .r_valid_o        (r_valid_o),
        .r_rdata_o        (r_rdata_o),
        .err_o            (err_o),
        .master_req_o     (master_req_o),
        .master_add_o     (master_add_o),
        .master_we_o      (master_we_o),
        .master_wdata_o   (master_wdata_o),
        .master_be_o      (master_be_o),
        .master_gnt_i     (mgnt),
        .master_r_valid_i (mrv),
        .master_r_rdata_i (mrdata),
        .spurious_o       (spurious_o),
        .busy_o           (busy_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_txn    = 0;

    // Transaction-level model: a pending (ungranted) request and an
    // outstanding (granted, awaiting response) one, plus the next RR start.
    bit m_pend = 0;
    int m_pend_own = 0;
    bit m_out = 0;
    int m_out_own = 0;
    int m_age = 0;
    int m_rr = 0;
    logic [NR-1:0] last_gnt = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Settle, predict this cycle's outputs, compare, and advance the model
    // to reflect the upcoming rising edge.
    task automatic eval();
        logic [NR-1:0]         e_gnt, e_rv, e_err;
        logic [NR-1:0][BW-1:0] e_rdata;
        logic                  e_mreq, e_spur, e_busy;
        logic [BW-1:0]         e_add, e_wdata;
        logic                  e_we;
        logic [BW/8-1:0]       e_be;
        int sel;
        #1;
        e_gnt = '0; e_rv = '0; e_err = '0; e_rdata = '0;
        e_mreq = 1'b0; e_spur = 1'b0; e_busy = 1'b0;
        sel = -1;
        if (!rst_ni || !dmactive) begin
            m_pend = 0; m_out = 0; m_age = 0; m_rr = 0;
        end else begin
            e_busy = m_pend || m_out;
            if (m_out) begin
                if (mrv) begin
                    e_rv[m_out_own] = 1'b1;
                    e_rdata[m_out_own] = mrdata;
                    n_txn++;
                    $display("txn %0d: owner=%0d response rdata=%h", n_txn, m_out_own, mrdata);
                    m_rr = (m_out_own + 1) % NR;
                    m_out = 0;
                end else if (m_age == TC - 1) begin
                    e_err[m_out_own] = 1'b1;
                    n_txn++;
                    $display("txn %0d: owner=%0d timeout", n_txn, m_out_own);
                    m_rr = (m_out_own + 1) % NR;
                    m_out = 0;
                end else begin
                    m_age++;
                end
            end else begin
                e_spur = mrv;
                if (m_pend) sel = m_pend_own;
                else
                    for (int k = 0; k < NR; k++)
                        if (sel < 0 && req[(m_rr + k) % NR]) sel = (m_rr + k) % NR;
                if (sel >= 0) begin
                    e_mreq = 1'b1;
                    if (mgnt) begin
                        e_gnt[sel] = 1'b1;
                        m_out = 1; m_out_own = sel; m_age = 0; m_pend = 0;
                    end else begin
                        m_pend = 1; m_pend_own = sel;
                    end
                end
            end
        end
        e_add   = e_mreq ? add[sel]   : '0;
        e_we    = e_mreq ? we[sel]    : 1'b0;
        e_wdata = e_mreq ? wdata[sel] : '0;
        e_be    = e_mreq ? be[sel]    : '0;
        chk("master_req", 128'(master_req_o), 128'(e_mreq));
        chk("master_add", 128'(master_add_o), 128'(e_add));
        chk("master_we", 128'(master_we_o), 128'(e_we));
        chk("master_wdata", 128'(master_wdata_o), 128'(e_wdata));
        chk("master_be", 128'(master_be_o), 128'(e_be));
        chk("gnt", 128'(gnt_o), 128'(e_gnt));
        chk("r_valid", 128'(r_valid_o), 128'(e_rv));
        chk("r_rdata", 128'(r_rdata_o), 128'(e_rdata));
        chk("err", 128'(err_o), 128'(e_err));
        chk("spurious", 128'(spurious_o), 128'(e_spur));
        chk("busy", 128'(busy_o), 128'(e_busy));
        last_gnt = e_gnt;
    endtask

    task automatic tick();
        eval();
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        rst_ni = 1'b0; dmactive = 1'b1;
        req = '0; we = '0; add = '0; wdata = '0; be = '0;
        mgnt = 1'b0; mrv = 1'b0; mrdata = '0;
        for (int i = 0; i < NR; i++) begin
            add[i]   = 32'h1000_0000 + 32'(i * 16);
            wdata[i] = 32'hA5A5_0000 + 32'(i);
            be[i]    = 4'hF;
            we[i]    = 1'(i);
        end
        @(negedge clk);

        // Reset: outputs low even with requests and grant asserted.
        req = 2'b11; mgnt = 1'b1; mrv = 1'b1;
        tick(); tick();
        rst_ni = 1'b1; req = '0; mgnt = 1'b0; mrv = 1'b0;
        tick();

        // Both requesters held for four transactions: order 0,1,0,1.
        req = 2'b11; mgnt = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            tick();
            mrv = 1'b1; mrdata = 32'h1111_0000 + 32'(t);
            tick();
            mrv = 1'b0;
        end
        req = '0; mgnt = 1'b0;
        tick();

        // Single request, same-cycle grant, response three cycles later.
        req = 2'b01; mgnt = 1'b1; add[0] = 32'h0000_4000; wdata[0] = 32'h1234_5678;
        tick();
        req = '0; mgnt = 1'b0;
        tick(); tick();
        mrv = 1'b1; mrdata = 32'hDEAD_BEEF;
        tick();
        mrv = 1'b0;

        // Grant withheld five cycles; requester 1 joins in the third.
        req = 2'b01; add[0] = 32'h0000_5000;
        tick(); tick();
        req = 2'b11;
        tick(); tick(); tick();
        mgnt = 1'b1;
        tick();
        req = 2'b10; mrv = 1'b1; mrdata = 32'h0BAD_F00D;
        tick();
        mrv = 1'b0;
        tick();
        req = '0; mgnt = 1'b0;
        tick();
        mrv = 1'b1; mrdata = 32'hCAFE_0001;
        tick();
        mrv = 1'b0;

        // Timeout after eight response-less cycles, then a stray response.
        req = 2'b01; mgnt = 1'b1;
        tick();
        req = '0; mgnt = 1'b0;
        repeat (8) tick();
        tick();
        mrv = 1'b1; mrdata = 32'h5757_5757;
        tick();
        mrv = 1'b0;

        // DM deactivated mid-response wait; pointer returns to 0.
        req = 2'b10; mgnt = 1'b1;
        tick();
        req = '0; mgnt = 1'b0;
        tick();
        dmactive = 1'b0;
        tick();
        dmactive = 1'b1; req = 2'b11;
        tick();
        mrv = 1'b1;
        tick();
        mrv = 1'b0;

        // Asynchronous reset mid-hold, released before the next clock edge.
        rst_ni = 1'b0;
        eval();
        #1 rst_ni = 1'b1;
        eval();
        @(negedge clk);
        cyc++;
        mgnt = 1'b1;
        tick();
        req = 2'b10; mgnt = 1'b0; mrv = 1'b1;
        tick();
        mrv = 1'b0; req = '0;
        tick();

        // Randomized traffic; requesters hold payload until granted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i]   = 1'b1;
                    add[i]   = $urandom;
                    wdata[i] = $urandom;
                    we[i]    = 1'($urandom_range(0, 1));
                    be[i]    = 4'($urandom);
                end
            end
            mgnt     = 1'($urandom_range(0, 1));
            mrv      = ($urandom_range(0, 3) == 0);
            mrdata   = $urandom;
            dmactive = ($urandom_range(0, 49) != 0);
            tick();
            req = req & ~last_gnt;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
